vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates VGA raster timing and drives the output pins (HSync, VSync, RED, GREEN, BLUE) consumed by the VGA output interface and its monitor.
- Walks horizontal/vertical counters on a pixel clock-enable.
- Requests pixel colour from an upstream frame source through a fixed-latency fetch pipeline.
- Blanks colour outside the active area and keeps sync and colour cycle-aligned at the pins.

Parameters:
- COLOR_WIDTH, 4, bits per colour channel; same value as item_pack.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).
- SYNC_POL, 0, sync asserted level (0 = active-low).
- FETCH_LAT, 1, pix_ce ticks between pix_req and valid rgb_in; legal range 0..3.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pix_ce  in  1  pixel tick; all state advances only when high.
- pix_req  out  1  high while the counters are in the active area.
- x_req  out  clog2(H_ACTIVE)  requested column, valid with pix_req.
- y_req  out  clog2(V_ACTIVE)  requested row, valid with pix_req.
- rgb_in  in  3*COLOR_WIDTH  {R,G,B} from the source; sampled FETCH_LAT ticks after the request.
- frame_start  out  1  one-clk pulse at h_cnt==0, v_cnt==0 when pix_ce is high.
- HSync  out  1  horizontal sync.
- VSync  out  1  vertical sync.
- RED  out  COLOR_WIDTH  red channel.
- GREEN  out  COLOR_WIDTH  green channel.
- BLUE  out  COLOR_WIDTH  blue channel.

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and increments on pix_ce.
  - On wrap to 0, v_cnt increments, counting 0..V_TOTAL-1 and wrapping to 0.
  - Both counters hold when pix_ce is low.
- Request stage (combinational from counters):
  - pix_req = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
  - x_req = h_cnt and y_req = v_cnt when pix_req is high; otherwise 0.
- Sync decode:
  - hs_raw is high for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw uses the same rule on v_cnt.
- Delay line:
  - {active, hs_raw, vs_raw} pass through a FETCH_LAT-deep shift register, advanced only on pix_ce.
  - FETCH_LAT=0 means no delay.
- Output register, updated on pix_ce:
  - HSync = delayed hs_raw ? SYNC_POL : ~SYNC_POL; VSync uses the same rule.
  - RGB = delayed active ? rgb_in : 0.
- Latency: pins reflect a counter state FETCH_LAT+1 pix_ce ticks after it. Sync and colour of the same pixel always appear in the same cycle.
- Reset:
  - Counters go to 0 and the delay line clears to inactive / no-sync.
  - Outputs: HSync=VSync=~SYNC_POL, RED=GREEN=BLUE=0, frame_start=0.
  - Reset takes priority over pix_ce.
  - Reset mid-frame restarts at pixel (0,0); the first frame_start follows on the first pix_ce after reset deasserts.
- Boundaries:
  - Last visible pixel h_cnt=H_ACTIVE-1 is driven.
  - h_cnt=H_ACTIVE is blank even if rgb_in is nonzero.
  - Line wrap and frame wrap land on the same pix_ce without skipping a line.
- rgb_in is ignored whenever the delayed active flag is low.

Optional Feature:
- Macro VGA_TEST_PATTERN_EN.
- When defined:
  - Extra input pattern_sel (1 bit).
  - When pattern_sel=1, the colour source is replaced by 8 vertical bars, each H_ACTIVE/8 wide.
  - Bar index b = x/(H_ACTIVE/8).
  - RED = all-ones when b[2] is set, else 0; GREEN follows b[1]; BLUE follows b[0].
  - The bar colour enters the same delay line, so latency is unchanged.
  - pix_req is forced to 0 while pattern_sel=1.
- When not defined: no pattern_sel port; no pattern logic is synthesised.

Test Plan:
- Reset: assert rst for 3 clk with pix_ce=1 -> HSync=VSync=1, RGB=0, frame_start=0. After release, frame_start pulses on the first tick and pix_req=1 with x_req=0, y_req=0.
- Line timing, default params, FETCH_LAT=1, pix_ce=1 every clk:
  - HSync falls 658 ticks after frame_start and stays low for exactly 96 ticks.
  - Line period is 800 ticks.
- Frame timing:
  - VSync is low for 2 lines (1600 ticks) starting at line 490.
  - frame_start period is 420000 ticks.
- Colour passthrough/blanking: rgb_in = {x_req[3:0],y_req[3:0],4'hA} delayed FETCH_LAT.
  - RED/GREEN/BLUE match it over the active area.
  - RGB=0 throughout the porches, even with rgb_in=12'hFFF forced there.
- pix_ce gating: pix_ce high 1 clk in 4 -> identical pin sequence as the pix_ce=1 case, stretched 4x; outputs stable between ticks.
- Mid-frame reset and pattern:
  - rst pulsed at line 200, pixel 300 -> restart at (0,0) with correct sync.
  - With VGA_TEST_PATTERN_EN and pattern_sel=1: pixels 0..79 = 000, 80..159 = 00F, …, 560..639 = FFF.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Pixel fetch bus: raster position request out, colour back FETCH_LAT pixel ticks later.
// No handshake: the source must answer every request at the fixed latency.
interface vga_timing_gen_if #(
    parameter int COLOR_WIDTH = 4,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480
);
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);

    logic                     pix_req;
    logic [XW-1:0]            x_req;
    logic [YW-1:0]            y_req;
    logic [3*COLOR_WIDTH-1:0] rgb_in;

    modport master (output pix_req, x_req, y_req, input rgb_in);
    modport slave  (input pix_req, x_req, y_req, output rgb_in);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing, pixel fetch request and pin register; VGA_TEST_PATTERN_EN adds an 8-bar pattern.
// Latency: pins show a counter state FETCH_LAT+1 pix_ce ticks later; sync and colour stay aligned.
// Backpressure: none; pix_ce low freezes counters, delay line and pins.
module vga_timing_gen #(
    parameter int COLOR_WIDTH = 4,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_POL    = 1'b0,
    parameter int FETCH_LAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_ce,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                   pattern_sel,
`endif
    vga_timing_gen_if.master       fetch,
    output logic                   frame_start,
    output logic                   HSync,
    output logic                   VSync,
    output logic [COLOR_WIDTH-1:0] RED,
    output logic [COLOR_WIDTH-1:0] GREEN,
    output logic [COLOR_WIDTH-1:0] BLUE
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = $clog2(H_ACTIVE);
    localparam int YW      = $clog2(V_ACTIVE);
    localparam int RGBW    = 3 * COLOR_WIDTH;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = V_ACTIVE + V_FP + V_SYNC;

    typedef struct packed {
        logic       active;
        logic       hs;
        logic       vs;
`ifdef VGA_TEST_PATTERN_EN
        logic       pat;
        logic [2:0] bar;
`endif
    } dly_t;

    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            h_last;
    logic            v_last;
    logic            in_active;
    logic            req;
    dly_t            dly_in;
    dly_t            dly_out;
    logic [RGBW-1:0] rgb_nxt;
    logic [RGBW-1:0] rgb_q;

    assign h_last = (int'(h_cnt) == H_TOTAL - 1);
    assign v_last = (int'(v_cnt) == V_TOTAL - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign in_active = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);

`ifdef VGA_TEST_PATTERN_EN
    // The pattern replaces the source entirely, so stop asking it for pixels.
    assign req = in_active && !pattern_sel;
`else
    assign req = in_active;
`endif

    assign fetch.pix_req = req;
    assign fetch.x_req   = req ? h_cnt[XW-1:0] : '0;
    assign fetch.y_req   = req ? v_cnt[YW-1:0] : '0;

    assign frame_start = !rst && pix_ce && (h_cnt == '0) && (v_cnt == '0);

    always_comb begin
        dly_in        = '0;
        dly_in.active = in_active;
        dly_in.hs     = (int'(h_cnt) >= HS_BEG) && (int'(h_cnt) < HS_END);
        dly_in.vs     = (int'(v_cnt) >= VS_BEG) && (int'(v_cnt) < VS_END);
`ifdef VGA_TEST_PATTERN_EN
        dly_in.pat    = pattern_sel;
        dly_in.bar    = 3'(int'(h_cnt) / (H_ACTIVE / 8));
`endif
    end

    // Sync decode travels alongside the fetch so it meets its colour at the pin register.
    generate
        if (FETCH_LAT == 0) begin : g_no_dly
            assign dly_out = dly_in;
        end else begin : g_dly
            dly_t dly [FETCH_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < FETCH_LAT; i++) dly[i] <= '0;
                end else if (pix_ce) begin
                    dly[0] <= dly_in;
                    for (int i = 1; i < FETCH_LAT; i++) dly[i] <= dly[i-1];
                end
            end

            assign dly_out = dly[FETCH_LAT-1];
        end
    endgenerate

    always_comb begin
        rgb_nxt = '0;
        if (dly_out.active) begin
`ifdef VGA_TEST_PATTERN_EN
            if (dly_out.pat)
                rgb_nxt = {{COLOR_WIDTH{dly_out.bar[2]}},
                           {COLOR_WIDTH{dly_out.bar[1]}},
                           {COLOR_WIDTH{dly_out.bar[0]}}};
            else
`endif
                rgb_nxt = fetch.rgb_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            HSync <= ~SYNC_POL;
            VSync <= ~SYNC_POL;
            rgb_q <= '0;
        end else if (pix_ce) begin
            HSync <= dly_out.hs ? SYNC_POL : ~SYNC_POL;
            VSync <= dly_out.vs ? SYNC_POL : ~SYNC_POL;
            rgb_q <= rgb_nxt;
        end
    end

    assign RED   = rgb_q[3*COLOR_WIDTH-1:2*COLOR_WIDTH];
    assign GREEN = rgb_q[2*COLOR_WIDTH-1:COLOR_WIDTH];
    assign BLUE  = rgb_q[COLOR_WIDTH-1:0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster (24x13 pixels per frame).
// Driver pushes the expected per-cycle response; a monitor pops and compares after each edge.
module tb_vga_timing_gen;
    localparam int CW    = 4;
    localparam int HA    = 16;
    localparam int HFP   = 2;
    localparam int HSW   = 3;
    localparam int HBP   = 3;
    localparam int VA    = 8;
    localparam int VFP   = 1;
    localparam int VSW   = 2;
    localparam int VBP   = 2;
    localparam int FL    = 1;
    localparam int HT    = HA + HFP + HSW + HBP;
    localparam int VT    = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;

    typedef struct {
        bit              hs;
        bit              vs;
        logic [3*CW-1:0] rgb;
    } pins_t;

    typedef struct {
        bit    chk_req;
        bit    pr;
        int    x;
        int    y;
        bit    fs;
        pins_t pins;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_ce;
`ifdef VGA_TEST_PATTERN_EN
    logic          pattern_sel;
`endif
    logic          frame_start;
    logic          HSync;
    logic          VSync;
    logic [CW-1:0] RED;
    logic [CW-1:0] GREEN;
    logic [CW-1:0] BLUE;

    vga_timing_gen_if #(.COLOR_WIDTH(CW), .H_ACTIVE(HA), .V_ACTIVE(VA)) fif ();

    vga_timing_gen #(
        .COLOR_WIDTH(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(1'b0), .FETCH_LAT(FL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_ce      (pix_ce),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel (pattern_sel),
`endif
        .fetch       (fif),
        .frame_start (frame_start),
        .HSync       (HSync),
        .VSync       (VSync),
        .RED         (RED),
        .GREEN       (GREEN),
        .BLUE        (BLUE)
    );

    always #5 clk = ~clk;

    exp_t            exp_q[$];
    logic [3*CW-1:0] src_q[$];
    int              t;
    bit              pat_mode;
    pins_t           cur;
    int              errors;
    int              checks;
    int              cyc;

    function automatic pins_t idle_pins();
        pins_t p;
        p.hs  = 1'b1;
        p.vs  = 1'b1;
        p.rgb = '0;
        return p;
    endfunction

    // Pin levels for the pixel reached after s ticks since reset (negative: still flushing reset).
    function automatic pins_t pins_at(int s, bit pat);
        pins_t p;
        int    h;
        int    v;
        int    b;
        p = idle_pins();
        if (s < 0) return p;
        h = s % HT;
        v = (s / HT) % VT;
        p.hs = !(h >= HA + HFP && h < HA + HFP + HSW);
        p.vs = !(v >= VA + VFP && v < VA + VFP + VSW);
        if (h < HA && v < VA) begin
            if (pat) begin
                b = h / (HA / 8);
                p.rgb = {((b & 4) != 0) ? 4'hF : 4'h0,
                         ((b & 2) != 0) ? 4'hF : 4'h0,
                         ((b & 1) != 0) ? 4'hF : 4'h0};
            end else begin
                p.rgb = {4'(h), 4'(v), 4'hA};
            end
        end
        return p;
    endfunction

    function automatic logic [3*CW-1:0] junk();
        return ($urandom_range(0, 1) == 1) ? 12'hFFF : 12'($urandom);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, req);
        end
    endtask

    // One clock of stimulus: drive inputs, push the expected response, let the source answer.
    task automatic cycle(input bit r, input bit ce);
        exp_t e;
        int   h;
        int   v;
        @(negedge clk);
        rst    = r;
        pix_ce = ce;
`ifdef VGA_TEST_PATTERN_EN
        pattern_sel = pat_mode;
`endif
        if (r) begin
            src_q.delete();
            for (int i = 0; i < FL; i++) src_q.push_back(junk());
        end
        fif.rgb_in = src_q[0];
        h = t % HT;
        v = (t / HT) % VT;
        e.chk_req = !r;
        e.pr      = (h < HA) && (v < VA) && !pat_mode;
        e.x       = e.pr ? h : 0;
        e.y       = e.pr ? v : 0;
        e.fs      = !r && ce && (h == 0) && (v == 0);
        if (r) begin
            t   = 0;
            cur = idle_pins();
        end else if (ce) begin
            cur = pins_at(t - FL, pat_mode);
            t++;
        end
        e.pins = cur;
        exp_q.push_back(e);
        if (!r && ce) begin
            #1;
            src_q.push_back(fif.pix_req ? {4'(fif.x_req), 4'(fif.y_req), 4'hA} : junk());
            void'(src_q.pop_front());
        end
    endtask

    initial begin
        logic        r_s;
        logic        ce_s;
        logic        pr_s;
        logic        fs_s;
        logic [31:0] x_s;
        logic [31:0] y_s;
        exp_t        e;
        int          tick_no;
        int          last_fs;
        int          run;
        tick_no = 0;
        last_fs = -1;
        run     = 0;
        forever begin
            @(negedge clk);
            #3;
            r_s  = rst;
            ce_s = pix_ce;
            pr_s = fif.pix_req;
            fs_s = frame_start;
            x_s  = 32'(fif.x_req);
            y_s  = 32'(fif.y_req);
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() == 0) continue;
            e = exp_q.pop_front();
            if (e.chk_req) begin
                chk("pix_req", {31'd0, pr_s}, {31'd0, e.pr});
                chk("x_req", x_s, e.x);
                chk("y_req", y_s, e.y);
            end
            chk("frame_start", {31'd0, fs_s}, {31'd0, e.fs});
            chk("HSync", {31'd0, HSync}, {31'd0, e.pins.hs});
            chk("VSync", {31'd0, VSync}, {31'd0, e.pins.vs});
            chk("RGB", {20'd0, RED, GREEN, BLUE}, {20'd0, e.pins.rgb});
            if (r_s) begin
                tick_no = 0;
                last_fs = -1;
                run     = 0;
            end else if (ce_s) begin
                if (fs_s === 1'b1) begin
                    if (last_fs >= 0) chk("frame_period", tick_no - last_fs, FRAME);
                    last_fs = tick_no;
                end
                if (HSync === 1'b0) begin
                    run++;
                end else begin
                    if (run > 0) chk("hsync_width", run, HSW);
                    run = 0;
                end
                tick_no++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        pix_ce     = 1'b0;
        fif.rgb_in = '0;
        t          = 0;
        pat_mode   = 1'b0;
        cur        = idle_pins();
        errors     = 0;
        checks     = 0;
        cyc        = 0;
`ifdef VGA_TEST_PATTERN_EN
        pattern_sel = 1'b0;
`endif
        src_q.push_back(junk());

        repeat (3) cycle(1'b1, 1'b1);
        repeat (2 * FRAME) cycle(1'b0, 1'b1);
        for (int k = 0; k < 4 * FRAME; k++) cycle(1'b0, (k % 4) == 3);
        for (int k = 0; k < 2 * FRAME; k++) cycle(1'b0, $urandom_range(0, 2) != 0);

        // Mid-frame reset at line 5, pixel 10, with pix_ce high and low during reset.
        while ((t % FRAME) != 5 * HT + 10) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        repeat (FRAME + HT) cycle(1'b0, 1'b1);

`ifdef VGA_TEST_PATTERN_EN
        pat_mode = 1'b1;
        repeat (2) cycle(1'b1, 1'b1);
        repeat (FRAME + HT) cycle(1'b0, 1'b1);
        pat_mode = 1'b0;
        cycle(1'b1, 1'b1);
        repeat (HT) cycle(1'b0, 1'b1);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
